uart_rx: RTL
============

Name: uart_rx

Overview:
- Receive-side stage that consumes the serial stream produced by the UART transmitter (TX_OUT) and rebuilds the parallel byte.
- Frame format matches the TX exactly: start(0), 8 data bits LSB first, optional parity, stop(1).
- Runs on a clock OVERSAMPLE× the bit rate and uses majority-vote mid-bit sampling.
- Outputs one byte per frame, with a one-cycle valid strobe and error strobes; feeds the downstream byte consumer or FIFO.

Parameters:
- OVERSAMPLE, 8, clk cycles per serial bit; legal values are even and ≥4.
- DATA_W, 8, data bits per frame.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- RX_IN  in  1  serial line; idle high; asynchronous to clk
- PAR_EN  in  1  1 = frame carries a parity bit
- PAR_TYP  in  1  0 = parity bit is ~^data (odd); 1 = parity bit is ^data (even). Same encoding as the TX.
- P_DATA  out  DATA_W  received byte; holds its value until the next good frame
- DATA_VALID  out  1  one-cycle strobe: P_DATA is new and error-free
- PAR_ERR  out  1  one-cycle strobe: parity mismatch
- STOP_ERR  out  1  one-cycle strobe: stop bit sampled as 0
- Busy  out  1  high while a frame is being received (any state other than IDLE)

Behaviour:
- Clock and reset: single clock domain. Reset is synchronous and active-low; it is sampled on posedge clk only.
- Reset values: P_DATA=0, DATA_VALID=0, PAR_ERR=0, STOP_ERR=0, Busy=0, state=IDLE, all counters 0, synchronizer flops=1.
- Reset asserted mid-frame aborts the frame. The partial byte is discarded and no strobe is issued.
- Input synchronizer: RX_IN passes through a 2-flop synchronizer (reset value 1). All logic below uses the synchronized signal rx_s, so there are 2 cycles of input latency.
- Sampling:
  - An edge counter runs 0..OVERSAMPLE-1 inside each bit period.
  - The bit value is the majority of rx_s at counts MID-1, MID and MID+1, where MID=OVERSAMPLE/2.
  - The bit is decided at count MID+1.
- State machine (enum in uart_pkg):
  - IDLE: wait for rx_s == 0. Latch PAR_EN and PAR_TYP into frame registers, clear the edge counter, go to START. Config changes mid-frame have no effect.
  - START: at the decision point, a sampled 1 is a glitch: return to IDLE with no strobe. A sampled 0 continues to DATA once the bit period completes (count OVERSAMPLE-1).
  - DATA: at each decision point, shift the sample into data bit [bit_cnt], LSB first.
    - After DATA_W bits, go to PARITY if the latched PAR_EN is 1, otherwise go to STOP.
    - bit_cnt is 0..DATA_W-1 and wraps to 0 on exit.
  - PARITY: sample the parity bit. Compare it with the expected value computed from the shifted data using the latched PAR_TYP. Record a mismatch flag. Go to STOP at the end of the bit period.
  - STOP: at the decision point, evaluate the frame and go to IDLE immediately, without waiting out the stop period. This allows back-to-back frames with a single stop bit.
    - No errors: P_DATA <= shift register and DATA_VALID=1 in the next cycle.
    - Parity mismatch: PAR_ERR=1 in the next cycle.
    - Stop bit sampled as 0: STOP_ERR=1 in the next cycle.
    - Both errors may pulse in the same cycle.
    - DATA_VALID is never asserted together with either error, and P_DATA is not updated on an error.
- Latency: let t0 be the cycle in which IDLE sees rx_s == 0. Let F = 1 + DATA_W + PAR_EN.
  - The stop decision falls at t0 + F·OVERSAMPLE + MID+1.
  - DATA_VALID is high in the cycle after that.
- Busy is high from the START entry cycle through the STOP decision cycle.
- A line held low (break condition) gives STOP_ERR, then IDLE immediately re-detects a start. This is acceptable and needs no special case.

Decomposition:
- uart_pkg holds:
  - typedef enum {IDLE, START, DATA, PARITY, STOP} uart_state_e, shared with the TX.
  - localparam PAR_ODD=0, PAR_EVEN=1.
  - function parity_calc(data, par_typ).
- One sub-module, uart_rx_sampler: contains the synchronizer, the edge counter and the majority vote. It outputs rx_s, sample_bit, sample_stb (decision point) and bit_end (count OVERSAMPLE-1), and has a clear input driven by the FSM.

Test Plan:
- PAR_EN=0, send 0xA5 with clean bits at OVERSAMPLE=8 -> DATA_VALID pulses once and P_DATA=0xA5 exactly at the latency formula (t0+9·8+5+1); no error strobes.
- PAR_EN=1, PAR_TYP=0, send 0x3C with parity bit 1 -> P_DATA=0x3C, DATA_VALID=1. Repeat with parity bit forced to 0 -> PAR_ERR=1, DATA_VALID=0, P_DATA stays 0x3C.
- Frame 0x81, PAR_EN=1, PAR_TYP=1, stop bit forced to 0 -> STOP_ERR=1, DATA_VALID=0. Send 0xFF with stop=0 and a wrong parity bit -> PAR_ERR and STOP_ERR pulse in the same cycle.
- 2-cycle low glitch on RX_IN while idle -> START rejects it and returns to IDLE, Busy drops, no strobes. Next frame 0x5A is then received correctly.
- Back-to-back frames 0x01, 0xFE, 0x7F with one stop bit each (loopback from the TX with the TX clock at rate/8) -> three DATA_VALID pulses with matching bytes. Injected single-sample noise at count MID-1 is rejected by the majority vote.
- Assert reset for 1 cycle during DATA bit 4 of 0xC3 -> all outputs return to their reset values in the next cycle and no strobe is issued. The following frame 0x44 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, parity-type codes and the
// parity helper used by both the transmit and receive sides.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam logic PAR_ODD  = 1'b0;
  localparam logic PAR_EVEN = 1'b1;

  // Expected parity bit; data is zero-extended so any width up to 32 bits fits.
  function automatic logic parity_calc(input logic [31:0] data, input logic par_typ);
    logic w_par;
    if (par_typ == PAR_EVEN) begin
      w_par = ^data;
    end else begin
      w_par = ~^data;
    end
    return w_par;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Input synchronizer, per-bit edge counter and three-sample majority vote
// around the middle of each bit period.
module uart_rx_sampler #(
  parameter int OVERSAMPLE = 8
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_rx,
  input  logic i_clear,
  output logic o_rx_s,
  output logic o_sample_bit,
  output logic o_sample_stb,
  output logic o_bit_end
);

  localparam int MID = OVERSAMPLE / 2;
  localparam int CW  = $clog2(OVERSAMPLE);

  logic          r_sync1;
  logic          r_sync2;
  logic [CW-1:0] r_cnt;
  logic          r_vote0;
  logic          r_vote1;

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_rx;
      r_sync2 <= r_sync1;
    end
  end

  // Edge counter within one bit period.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (r_cnt == CW'(OVERSAMPLE - 1)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Capture the two early votes; the third is the live sample at MID+1.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_vote0 <= 1'b1;
      r_vote1 <= 1'b1;
    end else begin
      if (r_cnt == CW'(MID - 1)) begin
        r_vote0 <= r_sync2;
      end
      if (r_cnt == CW'(MID)) begin
        r_vote1 <= r_sync2;
      end
    end
  end

  assign o_rx_s       = r_sync2;
  assign o_sample_bit = (r_vote0 & r_vote1) | (r_vote0 & r_sync2) | (r_vote1 & r_sync2);
  assign o_sample_stb = (r_cnt == CW'(MID + 1));
  assign o_bit_end    = (r_cnt == CW'(OVERSAMPLE - 1));

endmodule

// File: rtl/uart_rx.sv
// UART receiver: rebuilds start/data/parity/stop frames into parallel bytes
// with one-cycle valid and error strobes.
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 8,
  parameter int DATA_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RX_IN,
  input  logic              PAR_EN,
  input  logic              PAR_TYP,
  output logic [DATA_W-1:0] P_DATA,
  output logic              DATA_VALID,
  output logic              PAR_ERR,
  output logic              STOP_ERR,
  output logic              Busy
);

  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic              w_rx_s;
  logic              w_bit;
  logic              w_stb;
  logic              w_bit_end;
  logic              w_clear;
  uart_state_e       w_next;

  uart_state_e       r_state;
  logic [BW-1:0]     r_bit_cnt;
  logic [DATA_W-1:0] r_shift;
  logic              r_par_en;
  logic              r_par_typ;
  logic              r_par_err;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              r_perr;
  logic              r_serr;
  logic              r_busy;

  // Restarting the counter on every return to IDLE makes the detection cycle count 0.
  assign w_clear = (w_next == IDLE);

  uart_rx_sampler #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_sampler (
    .i_clk       (clk),
    .i_reset_n   (reset),
    .i_rx        (RX_IN),
    .i_clear     (w_clear),
    .o_rx_s      (w_rx_s),
    .o_sample_bit(w_bit),
    .o_sample_stb(w_stb),
    .o_bit_end   (w_bit_end)
  );

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (!w_rx_s) begin
          w_next = START;
        end else begin
          w_next = IDLE;
        end
      end
      START: begin
        if (w_stb && w_bit) begin
          w_next = IDLE;
        end else if (w_bit_end) begin
          w_next = DATA;
        end else begin
          w_next = START;
        end
      end
      DATA: begin
        if (w_bit_end && (r_bit_cnt == BW'(DATA_W - 1))) begin
          w_next = r_par_en ? PARITY : STOP;
        end else begin
          w_next = DATA;
        end
      end
      PARITY: begin
        if (w_bit_end) begin
          w_next = STOP;
        end else begin
          w_next = PARITY;
        end
      end
      STOP: begin
        if (w_stb) begin
          w_next = IDLE;
        end else begin
          w_next = STOP;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Frame datapath, state register and output strobes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_par_en  <= 1'b0;
      r_par_typ <= 1'b0;
      r_par_err <= 1'b0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_perr    <= 1'b0;
      r_serr    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != IDLE);
      r_valid <= 1'b0;
      r_perr  <= 1'b0;
      r_serr  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!w_rx_s) begin
            r_par_en  <= PAR_EN;
            r_par_typ <= PAR_TYP;
            r_bit_cnt <= '0;
            r_par_err <= 1'b0;
          end
        end
        DATA: begin
          if (w_stb) begin
            r_shift[r_bit_cnt] <= w_bit;
          end
          if (w_bit_end) begin
            if (r_bit_cnt == BW'(DATA_W - 1)) begin
              r_bit_cnt <= '0;
            end else begin
              r_bit_cnt <= r_bit_cnt + BW'(1);
            end
          end
        end
        PARITY: begin
          if (w_stb) begin
            r_par_err <= (w_bit != parity_calc(32'(r_shift), r_par_typ));
          end
        end
        STOP: begin
          // Good frames publish the byte; any error leaves the previous byte in place.
          if (w_stb) begin
            if (!r_par_err && w_bit) begin
              r_data  <= r_shift;
              r_valid <= 1'b1;
            end
            r_perr <= r_par_err;
            r_serr <= ~w_bit;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign P_DATA     = r_data;
  assign DATA_VALID = r_valid;
  assign PAR_ERR    = r_perr;
  assign STOP_ERR   = r_serr;
  assign Busy       = r_busy;

endmodule
